// File: rtl/bus_ctrl.sv
// Bus access sequencer: latches one CPU request, decodes its region, runs the
// memory or I/O access and returns a one-cycle ready pulse. Define BUS_TIMEOUT_EN for the I/O timeout.
module bus_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_WAIT   = 1,
  parameter int IO_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic              dec_en,
  output logic [ADDR_W-1:0] dec_add,
  input  logic [1:0]        dec_sel,
  output logic              mem_cs,
  output logic              io_cs,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_rdy
);

  localparam int MW_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [MW_W-1:0] MW_LOAD = MW_W'(MEM_WAIT);
`ifdef BUS_TIMEOUT_EN
  localparam int IO_W = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT + 1) : 1;
  localparam logic [IO_W-1:0] IO_LAST = IO_W'(IO_TIMEOUT - 1);
`endif

  if (MEM_WAIT < 0 || IO_TIMEOUT < 1) begin : g_bad_param
    $error("bus_ctrl: MEM_WAIT must be >= 0 and IO_TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_IO     = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [MW_W-1:0]   wcnt_q, wcnt_d;
`ifdef BUS_TIMEOUT_EN
  logic [IO_W-1:0]   iocnt_q, iocnt_d;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
`ifdef BUS_TIMEOUT_EN
      iocnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
`ifdef BUS_TIMEOUT_EN
      iocnt_q <= iocnt_d;
`endif
    end
  end

  // NOTE: every signal assigned in this block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
`ifdef BUS_TIMEOUT_EN
    iocnt_d = iocnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          we_d    = cpu_we;
          err_d   = 1'b0;
          rdata_d = '0;          // stays 0 for writes and errors
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (dec_sel)
          2'b01: begin
            wcnt_d  = MW_LOAD;
            state_d = S_MEM;
          end
          2'b10: begin
`ifdef BUS_TIMEOUT_EN
            iocnt_d = '0;
`endif
            state_d = S_IO;
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        endcase
      end
      S_MEM: begin
        if (wcnt_q == '0) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = S_RESP;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_IO: begin
        if (io_rdy) begin
          if (!we_q) rdata_d = io_rdata;
          state_d = S_RESP;
        end
`ifdef BUS_TIMEOUT_EN
        // io_rdy on the expiry cycle takes priority over the timeout
        else if (iocnt_q == IO_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (iocnt_q != '1) begin
          iocnt_d = iocnt_q + 1'b1;
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs are decoded from registered state only.
  always_comb begin
    cpu_ready = (state_q == S_RESP);
    cpu_rdata = cpu_ready ? rdata_q : '0;
    cpu_err   = cpu_ready & err_q;
    dec_en    = (state_q == S_DECODE);
    dec_add   = dec_en ? addr_q : '0;
    mem_cs    = (state_q == S_MEM);
    io_cs     = (state_q == S_IO);
    bus_we    = (mem_cs | io_cs) & we_q;
    bus_addr  = (mem_cs | io_cs) ? addr_q : '0;
    bus_wdata = (mem_cs | io_cs) ? wdata_q : '0;
  end

endmodule
